icache: RTL and testbench

Direct-mapped instruction cache feeding the instruction fetch stage. Answers the fetch stage's current `pc` combinationally on a hit with one raw instruction (32-bit, or 16-bit compressed zero-extended) and its length. On a miss it fills whole lines from the memory manager through a word-serial request/response handshake. Instructions may be 2-byte aligned and may straddle two cache lines.

---
 rtl/icache.sv | 115 +++++++++++
 tb/tb_icache.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with word-serial line refill and straddle support
module icache #(
    parameter int LINE_WIDTH  = 4,
    parameter int INDEX_WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc,
    input  logic        ask_for,
    output logic        give_you,
    output logic [31:0] give_you_ins,
    output logic [2:0]  offset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);
    localparam int TAG_W  = 32 - LINE_WIDTH - INDEX_WIDTH;
    localparam int HW_W   = LINE_WIDTH + INDEX_WIDTH - 1;
    localparam int CNT_W  = LINE_WIDTH - 2;
    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int HALVES = 1 << HW_W;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_mem [LINES];
    logic [15:0]            data_mem [HALVES];
    logic [30:0]            lo_ha, hi_ha;
    logic [INDEX_WIDTH-1:0] lo_idx, hi_idx, fill_idx;
    logic [15:0]            lo_half, hi_half;
    logic                   lo_hit, hi_hit, need_hi, hit, fill_we, fill_last;
    logic [31:0]            miss_base;
    logic                   unused_pc0;

    assign unused_pc0 = pc[0];
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    // Halfword-granular lookup of pc and pc+2; the hi half only matters for full-length instructions
    always_comb begin
        lo_ha        = pc[31:1];
        hi_ha        = lo_ha + 31'd1;
        lo_idx       = lo_ha[HW_W-1:LINE_WIDTH-1];
        hi_idx       = hi_ha[HW_W-1:LINE_WIDTH-1];
        lo_half      = data_mem[lo_ha[HW_W-1:0]];
        hi_half      = data_mem[hi_ha[HW_W-1:0]];
        lo_hit       = valid_q[lo_idx] && (tag_mem[lo_idx] == lo_ha[30:HW_W]);
        hi_hit       = valid_q[hi_idx] && (tag_mem[hi_idx] == hi_ha[30:HW_W]);
        need_hi      = lo_half[1:0] == 2'b11;
        hit          = lo_hit && (!need_hi || hi_hit);
        miss_base    = lo_hit ? {hi_ha[30:LINE_WIDTH-1], {LINE_WIDTH{1'b0}}}
                              : {lo_ha[30:LINE_WIDTH-1], {LINE_WIDTH{1'b0}}};
        fill_idx     = mem_addr_q[LINE_WIDTH+INDEX_WIDTH-1:LINE_WIDTH];
        fill_we      = rdy_in && (state_q == FILL) && mem_valid;
        fill_last    = &cnt_q;
        give_you     = rdy_in && ask_for && (state_q == IDLE) && hit;
        give_you_ins = need_hi ? {hi_half, lo_half} : {16'b0, lo_half};
        offset       = need_hi ? 3'd4 : 3'd2;
    end

    // Miss starts a fill of the first missing line; each accepted word advances until the line is complete
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        if (rdy_in && (state_q == IDLE) && ask_for && !hit) begin
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_addr_d = miss_base;
            cnt_d      = '0;
        end else if (fill_we) begin
            cnt_d      = cnt_q + CNT_W'(1);
            mem_addr_d = mem_addr_q + 32'd4;
            if (fill_last) begin
                valid_d[fill_idx] = 1'b1;
                mem_req_d         = 1'b0;
                state_d           = IDLE;
            end
        end
    end

    // Control state with asynchronous reset; valid bits are only ever cleared here
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays need no reset: they are qualified by the valid bits
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_mem[{fill_idx, cnt_q, 1'b0}] <= mem_data[15:0];
            data_mem[{fill_idx, cnt_q, 1'b1}] <= mem_data[31:16];
            if (fill_last) tag_mem[fill_idx] <= mem_addr_q[31:LINE_WIDTH+INDEX_WIDTH];
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache with a word-serial memory responder
module tb_icache;
    logic        clk_in, rst_in, rdy_in, ask_for, give_you, mem_req, mem_valid;
    logic [31:0] pc, give_you_ins, mem_addr, mem_data;
    logic [2:0]  offset;

    typedef struct packed {
        logic [31:0] ins;
        logic [2:0]  off;
    } res_t;

    res_t        res_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_bad = 0;

    icache dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc(pc), .ask_for(ask_for),
        .give_you(give_you), .give_you_ins(give_you_ins), .offset(offset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {~a[15:0], a[15:0] | 16'h0003};
    endfunction

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_give(output int cyc);
        res_t r;
        cyc = 0;
        #1;
        while (!give_you && cyc < 300) begin
            @(negedge clk_in);
            #1;
            cyc++;
        end
        chk("give_you", {31'b0, give_you}, 32'd1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("ins", give_you_ins, r.ins);
            chk("offset", {29'b0, offset}, {29'b0, r.off});
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ins, input logic [2:0] off);
        int n0, cyc;
        @(negedge clk_in);
        n0 = exp_addr_q.size();
        pc = a;
        ask_for = 1'b1;
        res_q.push_back({ins, off});
        wait_give(cyc);
        chk("latency", 32'(cyc), 32'(2 * n0));
        chk("fills_done", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clk_in);
        chk("saw_valid", {31'b0, mem_valid}, 32'd1);
    endtask

    // Memory responder: one-cycle pulse, one idle cycle between words; address checked when accepted
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk_in);
            #1;
            if (mem_valid) mem_valid = 1'b0;
            else if (mem_req && !rst_in) begin
                mem_valid = 1'b1;
                mem_data  = mem_rd(mem_addr);
                if (rdy_in) begin
                    if (exp_addr_q.size() == 0) chk("req_unexpected", {31'b0, mem_req}, 32'd0);
                    else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
        end
    end

    // No instruction may be handed out while a fill is outstanding
    initial forever begin
        @(negedge clk_in);
        #1;
        if (mem_req) chk("no_give_in_fill", {31'b0, give_you}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_in = 1'b1; rdy_in = 1'b1; ask_for = 1'b1; pc = '0;
        mem[32'h00] = 32'h00000013; mem[32'h04] = 32'h11; mem[32'h08] = 32'h22; mem[32'h0C] = 32'h33;
        mem[32'h10] = 32'h00004501; mem[32'h100] = 32'h12345677;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_give_you", {31'b0, give_you}, 32'd0);
        ask_for = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        push_line(32'h0);
        fetch(32'h0, 32'h00000013, 3'd4);
        push_line(32'h10);
        fetch(32'h10, 32'h00004501, 3'd2);
        fetch(32'h12, 32'h00000000, 3'd2);
        fetch(32'h4, 32'h00000011, 3'd2);
        fetch(32'h8, 32'h00000022, 3'd2);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1 chk("rdy_low_give", {31'b0, give_you}, 32'd0);
        rdy_in = 1'b1;
        #1 chk("rdy_high_give", {31'b0, give_you}, 32'd1);
        fetch(32'h0, 32'h00000013, 3'd4);
        push_line(32'h100);
        fetch(32'h100, 32'h12345677, 3'd4);
        push_line(32'h0);
        fetch(32'h0, 32'h00000013, 3'd4);
        push_line(32'h20);
        push_line(32'h40);
        @(negedge clk_in);
        pc = 32'h20;
        ask_for = 1'b1;
        wait_valid();
        pc = 32'h40;
        res_q.push_back({32'hFFBF0043, 3'd4});
        wait_give(cyc);
        chk("redirect_fills_done", 32'(exp_addr_q.size()), 32'd0);
        fetch(32'h20, 32'hFFDF0023, 3'd4);
        push_line(32'h80);
        @(negedge clk_in);
        pc = 32'h80;
        res_q.push_back({32'hFF7F0083, 3'd4});
        wait_valid();
        rdy_in = 1'b0;
        repeat (3) begin
            #2;
            chk("stall_addr", mem_addr, 32'h84);
            chk("stall_req", {31'b0, mem_req}, 32'd1);
            @(negedge clk_in);
        end
        rdy_in = 1'b1;
        wait_give(cyc);
        chk("stall_fills_done", 32'(exp_addr_q.size()), 32'd0);
        push_line(32'hC0);
        @(negedge clk_in);
        pc = 32'hC0;
        wait_valid();
        #2;
        rst_in = 1'b1;
        ask_for = 1'b0;
        #1;
        chk("midfill_rst_req", {31'b0, mem_req}, 32'd0);
        chk("midfill_rst_addr", mem_addr, 32'd0);
        exp_addr_q.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        push_line(32'hC0);
        fetch(32'hC0, 32'hFF3F00C3, 3'd4);
        mem[32'h0C] = 32'h00930000;
        mem[32'h10] = 32'h00000010;
        push_line(32'h0);
        push_line(32'h10);
        fetch(32'h0E, 32'h00100093, 3'd4);
        @(negedge clk_in);
        ask_for = 1'b0;
        #1 chk("no_ask_give", {31'b0, give_you}, 32'd0);
        repeat (2) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
